// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
//   boot_state_e   : loader FSM state encoding (7 states, 3 bits)
//   SYNC_BYTE      : frame start marker
//   BYTES_PER_WORD : payload bytes per instruction word
package boot_pkg;

    typedef enum logic [2:0] {
        S_SYNC   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE      = 8'h55;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
//   rx_data/rx_valid/rx_frame_err : bytes from the UART deserializer
//   mem_we/mem_addr/mem_wd        : single-cycle writes into instruction memory
// master: the loader side (consumes bytes, drives the memory write port).
// slave : the environment side (UART RX feeding in, instruction memory receiving).
interface uart_boot_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_frame_err;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [DATA_WIDTH-1:0] mem_wd;

    modport master (
        input  rx_data, rx_valid, rx_frame_err,
        output mem_we, mem_addr, mem_wd
    );

    modport slave (
        output rx_data, rx_valid, rx_frame_err,
        input  mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/boot_word_assembler.sv
// Assembles payload bytes into little-endian words and keeps a running XOR.
//   clear      : restart at byte lane 0 with a zero checksum
//   byte_valid : byte_in is a payload byte to absorb this cycle
//   word_out   : current word with byte_in merged into the active lane
//   word_ready : this byte completes a word (word_out is the full word)
//   csum       : XOR of every payload byte absorbed since clear
module boot_word_assembler
    import boot_pkg::*;
#(
    parameter int DATA_WIDTH = 8 * BYTES_PER_WORD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic [DATA_WIDTH-1:0] word_out,
    output logic                  word_ready,
    output logic [7:0]            csum
);

    logic [DATA_WIDTH-1:0] word_reg;
    logic [1:0]            byte_idx_reg;
    logic [7:0]            csum_reg;

    // Merge the incoming byte into its lane so the top can write the finished
    // word in the same cycle its last byte arrives.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign word_out[8*gi +: 8] = (byte_idx_reg == 2'(gi)) ? byte_in
                                                                  : word_reg[8*gi +: 8];
        end
    endgenerate

    assign word_ready = byte_valid && (byte_idx_reg == 2'(BYTES_PER_WORD - 1));
    assign csum       = csum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg     <= '0;
            byte_idx_reg <= '0;
            csum_reg     <= '0;
        end else if (clear) begin
            word_reg     <= '0;
            byte_idx_reg <= '0;
            csum_reg     <= '0;
        end else if (byte_valid) begin
            word_reg     <= word_out;
            byte_idx_reg <= byte_idx_reg + 2'd1;
            csum_reg     <= csum_reg ^ byte_in;
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a program image from the UART byte stream into instruction memory and
// holds the core in reset until a complete, checksum-verified image is present.
// Frame: 0x55, CNT_LO, CNT_HI, N*4 payload bytes (LSB first), CSUM (XOR of payload).
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : byte input and memory write port (master modport)
//   core_rst_n   : active-low core reset, high only once the image is verified
//   load_done    : image loaded and verified
//   load_err     : last load attempt failed (bad length, checksum, framing, timeout)
//   words_loaded : words written during the current attempt
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_boot_loader_if.master     bus,
    output logic                   core_rst_n,
    output logic                   load_done,
    output logic                   load_err,
    output logic [15:0]            words_loaded
);

    localparam int              TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_WORDS  = 17'd1 << ADDR_WIDTH;

    boot_state_e           state_reg;
    logic [15:0]           cnt_reg;
    logic [TW-1:0]         timer_reg;
    logic                  mem_we_reg;
    logic [31:0]           mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wd_reg;
    logic                  core_rst_n_reg;
    logic                  load_done_reg;
    logic                  load_err_reg;
    logic [15:0]           words_loaded_reg;

    logic                  loading;
    logic                  go_err;
    logic                  sync_seen;
    logic                  asm_valid;
    logic                  asm_ready;
    logic [DATA_WIDTH-1:0] asm_word;
    logic [7:0]            asm_csum;
    logic [15:0]           cnt_full;

    assign loading   = (state_reg == S_CNT_LO) || (state_reg == S_CNT_HI) ||
                       (state_reg == S_DATA)   || (state_reg == S_CSUM);
    // A framing error always wins over the byte it arrived with; a timeout can
    // only fire in a cycle with no byte.
    assign go_err    = loading && (bus.rx_frame_err ||
                                   (!bus.rx_valid && timer_reg == TIMER_LAST));
    assign sync_seen = ((state_reg == S_SYNC) || (state_reg == S_ERR)) &&
                       bus.rx_valid && (bus.rx_data == SYNC_BYTE);
    assign asm_valid = (state_reg == S_DATA) && bus.rx_valid && !bus.rx_frame_err;
    assign cnt_full  = {bus.rx_data, cnt_reg[7:0]};

    boot_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (sync_seen),
        .byte_valid (asm_valid),
        .byte_in    (bus.rx_data),
        .word_out   (asm_word),
        .word_ready (asm_ready),
        .csum       (asm_csum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_SYNC;
            cnt_reg          <= '0;
            timer_reg        <= '0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wd_reg       <= '0;
            core_rst_n_reg   <= 1'b0;
            load_done_reg    <= 1'b0;
            load_err_reg     <= 1'b0;
            words_loaded_reg <= '0;
        end else begin
            mem_we_reg <= 1'b0;

            if (loading && !bus.rx_valid)
                timer_reg <= timer_reg + 1'b1;
            else
                timer_reg <= '0;

            if (go_err) begin
                state_reg    <= S_ERR;
                load_err_reg <= 1'b1;
            end else begin
                case (state_reg)
                    S_SYNC, S_ERR: begin
                        if (sync_seen) begin
                            state_reg        <= S_CNT_LO;
                            load_err_reg     <= 1'b0;
                            words_loaded_reg <= '0;
                        end
                    end
                    S_CNT_LO: begin
                        if (bus.rx_valid) begin
                            cnt_reg[7:0] <= bus.rx_data;
                            state_reg    <= S_CNT_HI;
                        end
                    end
                    S_CNT_HI: begin
                        if (bus.rx_valid) begin
                            cnt_reg <= cnt_full;
                            if ({1'b0, cnt_full} > MAX_WORDS) begin
                                state_reg    <= S_ERR;
                                load_err_reg <= 1'b1;
                            end else if (cnt_full == 16'd0) begin
                                state_reg <= S_CSUM;
                            end else begin
                                state_reg <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (asm_ready) begin
                            mem_we_reg       <= 1'b1;
                            mem_wd_reg       <= asm_word;
                            mem_addr_reg     <= {14'd0, words_loaded_reg, 2'b00};
                            words_loaded_reg <= words_loaded_reg + 16'd1;
                            if (words_loaded_reg + 16'd1 == cnt_reg)
                                state_reg <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (bus.rx_valid) begin
                            if (bus.rx_data == asm_csum) begin
                                state_reg      <= S_DONE;
                                load_done_reg  <= 1'b1;
                                core_rst_n_reg <= 1'b1;
                            end else begin
                                state_reg    <= S_ERR;
                                load_err_reg <= 1'b1;
                            end
                        end
                    end
                    default: ; // S_DONE: sticky until rst_n
                endcase
            end
        end
    end

    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wd    = mem_wd_reg;
    assign core_rst_n    = core_rst_n_reg;
    assign load_done     = load_done_reg;
    assign load_err      = load_err_reg;
    assign words_loaded  = words_loaded_reg;

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_rst_n;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    uart_boot_loader_if #(.DATA_WIDTH(32)) bif ();

    uart_boot_loader #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (6),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bif),
        .core_rst_n   (core_rst_n),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always @(negedge clk) begin
        if (bif.mem_we === 1'b1) begin
            wr_addr_q.push_back(bif.mem_addr);
            wr_data_q.push_back(bif.mem_wd);
        end
    end

    typedef struct {
        logic [7:0]  b;
        logic        ferr;
        logic        done;
        logic        err;
        logic        crst;
        logic [15:0] words;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ferr);
        @(negedge clk);
        bif.rx_data      = b;
        bif.rx_valid     = 1'b1;
        bif.rx_frame_err = ferr;
        @(negedge clk);
        bif.rx_valid     = 1'b0;
        bif.rx_frame_err = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic ferr, input logic done,
                                input logic err, input logic crst, input logic [15:0] words);
        vec_t v;
        v.b = b; v.ferr = ferr; v.done = done; v.err = err; v.crst = crst; v.words = words;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] seq[$];
        bif.rx_data      = 8'h00;
        bif.rx_valid     = 1'b0;
        bif.rx_frame_err = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst mem_we",       32'(bif.mem_we), 32'd0);
        check("rst core_rst_n",   32'(core_rst_n), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst load_done",    32'(load_done), 32'd0);
        check("rst load_err",     32'(load_err), 32'd0);
        check("rst words_loaded", 32'(words_loaded), 32'd0);
        check("rst mem_addr",     bif.mem_addr, 32'd0);
        check("rst mem_wd",       bif.mem_wd, 32'd0);

        // Bad checksum, then the good image; CSUM 0xBA = XOR of 13 00 00 20 04 00 01 8C
        //                  byte   ferr  done err crst words
        vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        vecs.push_back(mk(8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        vecs.push_back(mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        vecs.push_back(mk(8'h8C, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2));
        vecs.push_back(mk(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2));
        vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        vecs.push_back(mk(8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        vecs.push_back(mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        vecs.push_back(mk(8'h8C, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2));
        vecs.push_back(mk(8'hBA, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2));
        vecs.push_back(mk(8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2));
        vecs.push_back(mk(8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2));

        foreach (vecs[i]) begin
            send_byte(vecs[i].b, vecs[i].ferr);
            check($sformatf("vec%0d load_done", i),    32'(load_done),    32'(vecs[i].done));
            check($sformatf("vec%0d load_err", i),     32'(load_err),     32'(vecs[i].err));
            check($sformatf("vec%0d core_rst_n", i),   32'(core_rst_n),   32'(vecs[i].crst));
            check($sformatf("vec%0d words_loaded", i), 32'(words_loaded), 32'(vecs[i].words));
            $display("vec%0d byte=%02h ferr=%0b done=%0b err=%0b crst=%0b words=%0d",
                     i, vecs[i].b, vecs[i].ferr, load_done, load_err, core_rst_n, words_loaded);
        end
        settle();
        check("table write count", 32'(wr_addr_q.size()), 32'd4);
        if (wr_addr_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("table wr%0d addr", k), wr_addr_q[k], (k % 2 == 0) ? 32'h0 : 32'h4);
                check($sformatf("table wr%0d data", k), wr_data_q[k],
                      (k % 2 == 0) ? 32'h20000013 : 32'h8C010004);
            end
        end

        // Oversize count: 65 words with a 64-word memory
        do_reset();
        seq = '{8'h55, 8'h41, 8'h00};
        send_seq(seq);
        check("oversize load_err",   32'(load_err), 32'd1);
        check("oversize core_rst_n", 32'(core_rst_n), 32'd0);
        settle();
        check("oversize writes", 32'(wr_addr_q.size()), 32'd0);
        $display("seq oversize: err=%0b writes=%0d", load_err, wr_addr_q.size());

        // Exactly 64 words is accepted
        do_reset();
        seq = '{8'h55, 8'h40, 8'h00};
        send_seq(seq);
        check("max size load_err", 32'(load_err), 32'd0);
        $display("seq max size: err=%0b", load_err);

        // Zero length, matching and non-matching checksum
        do_reset();
        seq = '{8'h55, 8'h00, 8'h00, 8'h00};
        send_seq(seq);
        check("zero len load_done",  32'(load_done), 32'd1);
        check("zero len core_rst_n", 32'(core_rst_n), 32'd1);
        check("zero len words",      32'(words_loaded), 32'd0);
        settle();
        check("zero len writes", 32'(wr_addr_q.size()), 32'd0);
        $display("seq zero len good: done=%0b writes=%0d", load_done, wr_addr_q.size());
        do_reset();
        seq = '{8'h55, 8'h00, 8'h00, 8'h01};
        send_seq(seq);
        check("zero len bad load_err",  32'(load_err), 32'd1);
        check("zero len bad load_done", 32'(load_done), 32'd0);
        $display("seq zero len bad: err=%0b", load_err);

        // Timeout: error lands exactly 100 cycles after the last byte
        do_reset();
        seq = '{8'h55, 8'h01, 8'h00, 8'hAA};
        send_seq(seq);
        repeat (99) @(negedge clk);
        check("timeout at 99", 32'(load_err), 32'd0);
        @(negedge clk);
        check("timeout at 100", 32'(load_err), 32'd1);
        settle();
        check("timeout writes", 32'(wr_addr_q.size()), 32'd0);
        $display("seq timeout: err=%0b writes=%0d", load_err, wr_addr_q.size());

        // Framing error on the 2nd payload byte
        do_reset();
        seq = '{8'h55, 8'h01, 8'h00, 8'hAA};
        send_seq(seq);
        send_byte(8'hBB, 1'b1);
        check("frame err load_err", 32'(load_err), 32'd1);
        seq = '{8'hCC, 8'hDD};
        send_seq(seq);
        settle();
        check("frame err writes", 32'(wr_addr_q.size()), 32'd0);
        check("frame err words",  32'(words_loaded), 32'd0);
        $display("seq frame err: err=%0b writes=%0d", load_err, wr_addr_q.size());

        // Reset mid-DATA after one word has been written
        do_reset();
        seq = '{8'h55, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_seq(seq);
        check("mid pulse mem_we",   32'(bif.mem_we), 32'd1);
        check("mid pulse mem_wd",   bif.mem_wd, 32'h44332211);
        check("mid pulse mem_addr", bif.mem_addr, 32'h0);
        @(negedge clk);
        check("mid pulse ends",     32'(bif.mem_we), 32'd0);
        seq = '{8'hAA, 8'hBB};
        send_seq(seq);
        #2 rst_n = 1'b0;
        #1;
        check("async rst words",  32'(words_loaded), 32'd0);
        check("async rst mem_wd", bif.mem_wd, 32'd0);
        check("async rst err",    32'(load_err), 32'd0);
        $display("seq async reset: words=%0d mem_wd=%08h", words_loaded, bif.mem_wd);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();

        // Noise in S_SYNC is ignored, then a clean one-word image (CSUM 0x44)
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b1);
        check("noise load_err",  32'(load_err), 32'd0);
        check("noise load_done", 32'(load_done), 32'd0);
        seq = '{8'h55, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_seq(seq);
        check("post rst load_done", 32'(load_done), 32'd1);
        check("post rst words",     32'(words_loaded), 32'd1);
        settle();
        check("post rst writes", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            check("post rst wr addr", wr_addr_q[0], 32'h0);
            check("post rst wr data", wr_data_q[0], 32'h44332211);
        end
        $display("seq post reset image: done=%0b writes=%0d", load_done, wr_addr_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
